// File: rtl/rx_packet_ctrl.sv
// ---------------------------------------------------------------------------
// rx_packet_ctrl
//
// Receive-side packet controller. It consumes decoded, de-stuffed bytes from
// the line decoder. It checks the sync byte and the PID. Token and handshake
// packets are followed to their end-of-packet. Data payload goes into the
// data buffer. The last two bytes of every data packet are the CRC16, so they
// are held back and never written.
//
// Ports
//   clk                   rising-edge system clock
//   n_rst                 asynchronous active-low reset
//   byte_valid            one-cycle pulse, rx_byte is valid
//   rx_byte[7:0]          decoded, de-stuffed byte
//   eop                   one-cycle pulse, end of packet seen on the line
//   line_err              one-cycle pulse, bit-stuff or line-state violation
//   buffer_occupancy[6:0] current data buffer fill, 0..64
//   rx_packet[3:0]        PID of the last accepted packet
//   rx_data_ready         a complete, valid data packet is in the buffer
//   rx_transfer_active    a packet is being received (state != IDLE)
//   rx_error              the last packet was in error
//   flush                 one-cycle pulse that empties the buffer
//   store_rx_packet_data  one-cycle write strobe to the buffer
//   rx_packet_data[7:0]   byte written with the store strobe
// ---------------------------------------------------------------------------
module rx_packet_ctrl (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       byte_valid,
  input  logic [7:0] rx_byte,
  input  logic       eop,
  input  logic       line_err,
  input  logic [6:0] buffer_occupancy,
  output logic [3:0] rx_packet,
  output logic       rx_data_ready,
  output logic       rx_transfer_active,
  output logic       rx_error,
  output logic       flush,
  output logic       store_rx_packet_data,
  output logic [7:0] rx_packet_data
);

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [6:0] BUF_FULL  = 7'd64;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [2:0] {
    IDLE, PID, TOK1, TOK2, TOK_EOP, HS_EOP, DATA, DRAIN
  } state_t;

  state_t     state, state_n;
  logic [7:0] h0, h1, h0_n, h1_n;   // h0 = newest payload byte, h1 = older
  logic [1:0] count, count_n;       // number of valid bytes in h0/h1
  logic [3:0] rx_packet_n;
  logic       rx_error_n, rx_data_ready_n, flush_n, store_n;
  logic [7:0] rx_packet_data_n;
  logic       pid_ok;

  // A PID byte carries its 4-bit code in the low nibble and the complement
  // of that code in the high nibble.
  assign pid_ok = (rx_byte[7:4] == ~rx_byte[3:0]);

  // NOTE: every signal assigned in this block gets a default first. A path
  // that leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    state_n          = state;
    h0_n             = h0;
    h1_n             = h1;
    count_n          = count;
    rx_packet_n      = rx_packet;
    rx_error_n       = rx_error;
    rx_data_ready_n  = rx_data_ready;
    rx_packet_data_n = rx_packet_data;
    flush_n          = 1'b0;
    store_n          = 1'b0;

    // A line error aborts any packet in progress. It has priority over eop
    // and over byte_valid.
    if (state != IDLE && line_err) begin
      state_n    = DRAIN;
      rx_error_n = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (byte_valid) begin
            if (rx_byte == SYNC_BYTE) begin
              state_n         = PID;
              rx_error_n      = 1'b0;
              rx_data_ready_n = 1'b0;
            end else begin
              state_n    = DRAIN;
              rx_error_n = 1'b1;
            end
          end
        end

        PID: begin
          if (eop) begin
            state_n    = IDLE;
            rx_error_n = 1'b1;
          end else if (byte_valid) begin
            if (!pid_ok) begin
              state_n    = DRAIN;
              rx_error_n = 1'b1;
            end else begin
              case (rx_byte[3:0])
                PID_OUT, PID_IN: begin
                  state_n     = TOK1;
                  rx_packet_n = rx_byte[3:0];
                end
                PID_ACK, PID_NAK, PID_STALL: begin
                  state_n     = HS_EOP;
                  rx_packet_n = rx_byte[3:0];
                end
                PID_DATA0, PID_DATA1: begin
                  state_n     = DATA;
                  rx_packet_n = rx_byte[3:0];
                  flush_n     = 1'b1;
                  count_n     = 2'd0;
                end
                default: begin
                  state_n    = DRAIN;
                  rx_error_n = 1'b1;
                end
              endcase
            end
          end
        end

        TOK1, TOK2: begin
          // The two token bytes (address/endpoint/CRC5) are not stored.
          if (eop) begin
            state_n    = IDLE;
            rx_error_n = 1'b1;
          end else if (byte_valid) begin
            state_n = (state == TOK1) ? TOK2 : TOK_EOP;
          end
        end

        TOK_EOP, HS_EOP: begin
          if (eop) begin
            state_n = IDLE;
          end else if (byte_valid) begin
            state_n    = DRAIN;
            rx_error_n = 1'b1;
          end
        end

        DATA: begin
          if (eop) begin
            // A good data packet ends with exactly the two CRC bytes held.
            state_n = IDLE;
            if (count == 2'd2) rx_data_ready_n = 1'b1;
            else               rx_error_n      = 1'b1;
          end else if (byte_valid) begin
            if (count == 2'd2 && buffer_occupancy == BUF_FULL) begin
              state_n    = DRAIN;
              rx_error_n = 1'b1;
            end else begin
              if (count == 2'd2) begin
                store_n          = 1'b1;
                rx_packet_data_n = h1;
              end else begin
                count_n = count + 2'd1;
              end
              h1_n = h0;
              h0_n = rx_byte;
            end
          end
        end

        DRAIN: begin
          if (eop) state_n = IDLE;
        end

        default: state_n = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values that were present before the edge.
  // NOTE: the holding registers h0/h1 are reset along with the control state.
  // This leaves no register in an unknown state after reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state                <= IDLE;
      h0                   <= 8'h00;
      h1                   <= 8'h00;
      count                <= 2'd0;
      rx_packet            <= 4'h0;
      rx_error             <= 1'b0;
      rx_data_ready        <= 1'b0;
      rx_transfer_active   <= 1'b0;
      flush                <= 1'b0;
      store_rx_packet_data <= 1'b0;
      rx_packet_data       <= 8'h00;
    end else begin
      state                <= state_n;
      h0                   <= h0_n;
      h1                   <= h1_n;
      count                <= count_n;
      rx_packet            <= rx_packet_n;
      rx_error             <= rx_error_n;
      rx_data_ready        <= rx_data_ready_n;
      rx_transfer_active   <= (state_n != IDLE);
      flush                <= flush_n;
      store_rx_packet_data <= store_n;
      rx_packet_data       <= rx_packet_data_n;
    end
  end

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rx_packet_ctrl
//
// Self-checking bench for rx_packet_ctrl. The reference model works at packet
// level. It tracks which kind of packet is being received, how many token
// bytes have arrived, and a queue of payload bytes waiting to be written.
// The model is compared against every registered output after every clock.
// ---------------------------------------------------------------------------
module tb_rx_packet_ctrl;

  logic       clk;
  logic       n_rst;
  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       eop;
  logic       line_err;
  logic [6:0] buffer_occupancy;
  logic [3:0] rx_packet;
  logic       rx_data_ready;
  logic       rx_transfer_active;
  logic       rx_error;
  logic       flush;
  logic       store_rx_packet_data;
  logic [7:0] rx_packet_data;

  rx_packet_ctrl dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .byte_valid           (byte_valid),
    .rx_byte              (rx_byte),
    .eop                  (eop),
    .line_err             (line_err),
    .buffer_occupancy     (buffer_occupancy),
    .rx_packet            (rx_packet),
    .rx_data_ready        (rx_data_ready),
    .rx_transfer_active   (rx_transfer_active),
    .rx_error             (rx_error),
    .flush                (flush),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Observed activity, recorded from the DUT for the directed checks.
  int         n_stores = 0;
  int         n_flush  = 0;
  logic [7:0] st_log[$];

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_PID = 1, M_TOK = 2, M_HS = 3, M_DATA = 4, M_DRAIN = 5;

  int         m_mode;
  int         m_tok;           // token bytes received after the PID
  logic [7:0] m_q[$];          // payload bytes not yet written to the buffer
  logic [3:0] exp_pkt;
  logic       exp_err, exp_rdy, exp_flush, exp_store;
  logic [7:0] exp_data;

  task automatic model_reset();
    m_mode = M_IDLE; m_tok = 0; m_q.delete();
    exp_pkt = 4'h0; exp_err = 1'b0; exp_rdy = 1'b0;
    exp_flush = 1'b0; exp_store = 1'b0; exp_data = 8'h00;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b, input logic e,
                            input logic le, input logic [6:0] occ);
    logic [3:0] p;
    p = b[3:0];
    exp_flush = 1'b0;
    exp_store = 1'b0;
    if (m_mode != M_IDLE && le) begin
      m_mode = M_DRAIN; exp_err = 1'b1;
    end else begin
      case (m_mode)
        M_IDLE: if (v) begin
          if (b == 8'h80) begin m_mode = M_PID; exp_err = 1'b0; exp_rdy = 1'b0; end
          else begin m_mode = M_DRAIN; exp_err = 1'b1; end
        end
        M_PID: begin
          if (e) begin m_mode = M_IDLE; exp_err = 1'b1; end
          else if (v) begin
            if ((b[7:4] ^ b[3:0]) != 4'hF) begin m_mode = M_DRAIN; exp_err = 1'b1; end
            else if (p inside {4'h1, 4'h9}) begin m_mode = M_TOK; m_tok = 0; exp_pkt = p; end
            else if (p inside {4'h2, 4'hA, 4'hE}) begin m_mode = M_HS; exp_pkt = p; end
            else if (p inside {4'h3, 4'hB}) begin
              m_mode = M_DATA; exp_pkt = p; exp_flush = 1'b1; m_q.delete();
            end else begin m_mode = M_DRAIN; exp_err = 1'b1; end
          end
        end
        M_TOK: begin
          if (e) begin m_mode = M_IDLE; if (m_tok != 2) exp_err = 1'b1; end
          else if (v) begin
            if (m_tok == 2) begin m_mode = M_DRAIN; exp_err = 1'b1; end
            else m_tok++;
          end
        end
        M_HS: begin
          if (e) m_mode = M_IDLE;
          else if (v) begin m_mode = M_DRAIN; exp_err = 1'b1; end
        end
        M_DATA: begin
          if (e) begin
            m_mode = M_IDLE;
            if (m_q.size() == 2) exp_rdy = 1'b1; else exp_err = 1'b1;
          end else if (v) begin
            if (m_q.size() == 2 && occ == 7'd64) begin m_mode = M_DRAIN; exp_err = 1'b1; end
            else begin
              m_q.push_back(b);
              if (m_q.size() > 2) begin exp_store = 1'b1; exp_data = m_q.pop_front(); end
            end
          end
        end
        M_DRAIN: if (e) m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("rx_transfer_active", 32'(rx_transfer_active), 32'(m_mode != M_IDLE));
    check("rx_error",           32'(rx_error),             32'(exp_err));
    check("rx_data_ready",      32'(rx_data_ready),        32'(exp_rdy));
    check("rx_packet",          32'(rx_packet),            32'(exp_pkt));
    check("flush",              32'(flush),                32'(exp_flush));
    check("store",              32'(store_rx_packet_data), 32'(exp_store));
    check("rx_packet_data",     32'(rx_packet_data),       32'(exp_data));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic drive(input logic v, input logic [7:0] b, input logic e, input logic le);
    byte_valid = v; rx_byte = b; eop = e; line_err = le;
    @(posedge clk);
    model_step(v, b, e, le, buffer_occupancy);
    #1;
    compare_all();
    if (store_rx_packet_data) begin n_stores++; st_log.push_back(rx_packet_data); end
    if (flush) n_flush++;
    byte_valid = 1'b0; eop = 1'b0; line_err = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b); drive(1'b1, b, 1'b0, 1'b0); endtask
  task automatic send_eop();                     drive(1'b0, 8'h00, 1'b1, 1'b0); endtask
  task automatic idle_cycle();                   drive(1'b0, 8'h00, 1'b0, 1'b0); endtask

  // Random packet: sync (usually good), PID (usually legal), random-length
  // tail, occasional line errors and eop coinciding with a byte.
  task automatic random_packet();
    logic [3:0] pids[7];
    logic [7:0] bytes[$];
    int         k;
    logic [3:0] p;
    pids = '{4'h1, 4'h9, 4'h3, 4'hB, 4'h2, 4'hA, 4'hE};
    bytes.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h80);
    k = $urandom_range(0, 7);
    if (k == 7) bytes.push_back(8'($urandom));
    else begin p = pids[k]; bytes.push_back({~p, p}); end
    for (int i = 0; i < int'($urandom_range(0, 6)); i++) bytes.push_back(8'($urandom));
    buffer_occupancy = ($urandom_range(0, 3) == 0) ? 7'd64 : 7'($urandom_range(0, 63));
    foreach (bytes[i]) begin
      drive(1'b1, bytes[i], 1'b0, ($urandom_range(0, 40) == 0));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    drive(($urandom_range(0, 7) == 0), 8'($urandom), 1'b1, ($urandom_range(0, 20) == 0));
    for (int i = 0; i < int'($urandom_range(1, 3)); i++) idle_cycle();
  endtask

  // Watchdog: the stimulus is fixed-length, this only guards against a hang.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d/%0d", passed, total);
    $fatal(1, "time limit");
  end

  initial begin
    int s0, f0;
    n_rst = 1'b0; byte_valid = 1'b0; rx_byte = 8'h00; eop = 1'b0; line_err = 1'b0;
    buffer_occupancy = 7'd0;
    model_reset();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    n_rst = 1'b1;
    idle_cycle();

    // Token packet: PID OUT, two token bytes, eop.
    s0 = n_stores;
    send_byte(8'h80); send_byte(8'hE1); send_byte(8'h5A); send_byte(8'h3C);
    check("tok_active_before_eop", 32'(rx_transfer_active), 32'd1);
    send_eop();
    check("tok_active_after_eop", 32'(rx_transfer_active), 32'd0);
    check("tok_rx_packet", 32'(rx_packet), 32'd1);
    check("tok_stores", 32'(n_stores - s0), 32'd0);
    idle_cycle();

    // Data packet: DATA0, payload 11 22 33, CRC C0 DE.
    s0 = n_stores; f0 = n_flush; st_log.delete();
    send_byte(8'h80); send_byte(8'hC3);
    foreach (st_log[i]) st_log.delete(i);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'hC0); send_byte(8'hDE);
    send_eop();
    idle_cycle();
    check("data_flush_count", 32'(n_flush - f0), 32'd1);
    check("data_store_count", 32'(n_stores - s0), 32'd3);
    if (st_log.size() == 3) begin
      check("data_byte0", 32'(st_log[0]), 32'h11);
      check("data_byte1", 32'(st_log[1]), 32'h22);
      check("data_byte2", 32'(st_log[2]), 32'h33);
    end else begin
      check("data_log_size", 32'(st_log.size()), 32'd3);
    end
    check("data_ready", 32'(rx_data_ready), 32'd1);
    check("data_rx_packet", 32'(rx_packet), 32'd3);
    check("data_no_error", 32'(rx_error), 32'd0);

    // Bad PID check nibble: drains until eop, nothing stored.
    s0 = n_stores;
    send_byte(8'h80); send_byte(8'hE2);
    check("badpid_error", 32'(rx_error), 32'd1);
    send_byte(8'h12); send_byte(8'h34);
    check("badpid_draining", 32'(rx_transfer_active), 32'd1);
    send_eop();
    check("badpid_stores", 32'(n_stores - s0), 32'd0);
    idle_cycle();

    // Overflow: buffer full when the third payload byte would cause a store.
    s0 = n_stores;
    send_byte(8'h80); send_byte(8'hC3); send_byte(8'h11); send_byte(8'h22);
    buffer_occupancy = 7'd64;
    send_byte(8'h33);
    check("ovf_store_suppressed", 32'(n_stores - s0), 32'd0);
    check("ovf_error", 32'(rx_error), 32'd1);
    send_byte(8'h44); send_eop();
    buffer_occupancy = 7'd0;
    idle_cycle();

    // line_err together with eop during DATA.
    send_byte(8'h80); send_byte(8'h4B); send_byte(8'h11); send_byte(8'h22);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    check("lerr_error", 32'(rx_error), 32'd1);
    check("lerr_still_active", 32'(rx_transfer_active), 32'd1);
    check("lerr_not_ready", 32'(rx_data_ready), 32'd0);
    send_eop();
    idle_cycle();

    // Short data packet: one byte then eop.
    s0 = n_stores;
    send_byte(8'h80); send_byte(8'h4B); send_byte(8'hAA); send_eop();
    check("short_error", 32'(rx_error), 32'd1);
    check("short_not_ready", 32'(rx_data_ready), 32'd0);
    check("short_stores", 32'(n_stores - s0), 32'd0);
    idle_cycle();

    // Reset in the middle of a data packet, just as a store is being issued.
    send_byte(8'h80); send_byte(8'h4B);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    n_rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    n_rst = 1'b1;
    send_byte(8'h80); send_byte(8'h69); send_byte(8'h01); send_byte(8'h02); send_eop();
    check("after_reset_pkt", 32'(rx_packet), 32'd9);
    idle_cycle();

    // Randomized packets against the model.
    for (int n = 0; n < 300; n++) random_packet();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
